// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types, default sizes and bit helpers for the round-robin grant arbiter.
package rr_grant_arbiter_pkg;

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  localparam int REQ_W_DEF    = 4;
  localparam int MAX_HOLD_DEF = 16;

  // Isolate the lowest set bit: x & (~x + 1). Zero in, zero out.
  function automatic logic [31:0] lowest_one(input logic [31:0] x);
    return x & (~x + 32'd1);
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_onehot_to_idx.sv
// One-hot to binary encoder; an all-zero input encodes to index 0.
module onehot_to_idx #(
  parameter int REQ_W = 4,
  parameter int IDX_W = $clog2(REQ_W)
) (
  input  logic [REQ_W-1:0] onehot_i,
  output logic [IDX_W-1:0] idx_o
);

  // OR together the indices of all set bits; exact for a one-hot input.
  always_comb begin
    idx_o = '0;
    for (int n = 0; n < REQ_W; n++) begin
      if (onehot_i[n]) idx_o = idx_o | IDX_W'(n);
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: one registered, held grant over REQ_W requesters.
// The owner keeps the grant until done_i or until it drops its request; the
// priority pointer then rotates so the releasing owner has lowest priority.
// Optional hold limit: define RR_GRANT_ARBITER_HOLD_LIMIT_EN to force a
// release after MAX_HOLD grant cycles and expose hold_expired_o.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int REQ_W    = REQ_W_DEF,
  parameter int IDX_W    = $clog2(REQ_W),
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [REQ_W-1:0] req_i,
  input  logic             done_i,
  output logic [REQ_W-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_val_o,
`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
  output logic             hold_expired_o,
`endif
  output logic             busy_o
);

  // Reject degenerate configurations at elaboration time.
  if (REQ_W < 2 || MAX_HOLD < 1) begin : g_param_check
    $error("rr_grant_arbiter: REQ_W must be >= 2 and MAX_HOLD >= 1");
  end

  state_t           state_q;
  logic [REQ_W-1:0] grant_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] ptr_q;
  logic             val_q;
  logic             busy_q;

  logic [REQ_W-1:0] mask;
  logic [REQ_W-1:0] masked_req;
  logic [REQ_W-1:0] sel;
  logic [IDX_W-1:0] sel_idx;
  logic             owner_release;
  logic             release_now;

  // Rotated-priority pick: lowest request strictly above ptr, else lowest overall.
  always_comb begin
    mask = '0;
    for (int n = 0; n < REQ_W; n++) begin
      mask[n] = (IDX_W'(n) > ptr_q);
    end
    masked_req = req_i & mask;
    if (masked_req != '0) sel = REQ_W'(lowest_one(32'(masked_req)));
    else                  sel = REQ_W'(lowest_one(32'(req_i)));
  end

  onehot_to_idx #(
    .REQ_W (REQ_W),
    .IDX_W (IDX_W)
  ) u_enc (
    .onehot_i (sel),
    .idx_o    (sel_idx)
  );

  // The owner gives up the resource on done or by withdrawing its request.
  assign owner_release = done_i | ~req_i[idx_q];

`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             expire;
  logic             new_grant;

  assign expire = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1)) && !owner_release;
  assign release_now    = owner_release | expire;
  assign hold_expired_o = expire;
  assign new_grant = (|req_i) && ((state_q == IDLE) || release_now);

  // Hold counter: cleared on every new grant, counts grant cycles otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (new_grant)               cnt_d = '0;
    else if (state_q == GRANT)   cnt_d = cnt_q + CNT_W'(1);
  end

  // Hold counter register.
  always_ff @(posedge clk_i) begin
    if (srst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign release_now = owner_release;
`endif

  // Grant FSM with registered grant, index, valid, busy and priority pointer.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= IDX_W'(REQ_W - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q <= GRANT;
            grant_q <= sel;
            idx_q   <= sel_idx;
            val_q   <= 1'b1;
            busy_q  <= 1'b1;
            ptr_q   <= sel_idx;
          end
        end
        GRANT: begin
          if (release_now) begin
            if (|req_i) begin
              grant_q <= sel;
              idx_q   <= sel_idx;
              ptr_q   <= sel_idx;
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
              idx_q   <= '0;
              val_q   <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign grant_val_o = val_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one datapath resource among REQ_W requesters.
- Arbitration reuses the lowest-set-bit isolation performed by outer1bits, in the form x & (~x + 1), applied to a rotated-priority masked request vector.
- The grant is registered and held until the owner releases it.
- Sits between requester ports and the shared unit, and drives that unit's select and valid.

Parameters:
- REQ_W, 4, number of requesters (>= 2).
- IDX_W, $clog2(REQ_W), width of the grant index.
- MAX_HOLD, 16, maximum grant length in cycles. Used only with the optional feature.

Ports:
- clk_i  input  1  clock.
- srst_i  input  1  synchronous reset, active-high.
- req_i  input  REQ_W  per-requester request level. Bit n = requester n.
- done_i  input  1  current owner finishes; pulse, sampled only in GRANT.
- grant_o  output  REQ_W  one-hot grant, or all zero.
- grant_idx_o  output  IDX_W  binary index of the granted requester. Valid when grant_val_o = 1.
- grant_val_o  output  1  a grant is active.
- busy_o  output  1  resource owned; equals grant_val_o, registered separately for fanout.

Behaviour:
- Reset (srst_i = 1 at a clock edge):
  - grant_o = 0, grant_idx_o = 0, grant_val_o = 0, busy_o = 0.
  - FSM = IDLE.
  - Priority pointer ptr = REQ_W-1, so requester 0 has top priority after reset.
  - Reset mid-grant drops the grant on that edge. done_i is ignored in that cycle.
- FSM states: IDLE, GRANT.
- Arbitration function (combinational):
  - mask = bits strictly above ptr.
  - m = req_i & mask.
  - sel = (m != 0) ? lowest-set-bit(m) : lowest-set-bit(req_i).
  - Result is one-hot or zero. Index is derived by an encoder.
- IDLE:
  - If req_i != 0: next edge grant_o = sel, grant_idx_o = index(sel), grant_val_o = 1, ptr = index(sel), go to GRANT.
  - Latency is 1 cycle from the request being sampled to the grant being visible.
  - Otherwise stay in IDLE with outputs zero.
- GRANT: release occurs when done_i = 1, or when req_i[grant_idx_o] = 0 (owner withdrew).
  - On release with other requests pending (arbitrated with the updated ptr, so the releasing owner has lowest priority): back-to-back grant on the next edge, with no idle cycle. Stay in GRANT.
  - On release with no other pending request and the owner's request low: go to IDLE, outputs zero.
  - On done_i with the owner's req still high and no other requester: the same requester is re-granted on the next edge (grant_o unchanged).
  - Without release: grant_o, grant_idx_o and ptr are held.
  - Changes on non-owner req_i bits do not affect the current grant.
- Boundary conditions:
  - Simultaneous requests are resolved by rotation, never by fixed index.
  - ptr = REQ_W-1 wraps: the mask is empty, so the plain lowest set bit wins.
  - done_i in IDLE is ignored.
  - Invariants: grant_o is always one-hot or zero, and grant_val_o == |grant_o.

Optional Feature:
- Macro RR_GRANT_ARBITER_HOLD_LIMIT_EN.
- When defined:
  - A hold counter resets to 0 on every new grant and increments each GRANT cycle.
  - When count == MAX_HOLD-1 and no release has occurred, a forced release is treated as a release. The owner goes to lowest priority.
  - Pulse output hold_expired_o (1 bit, reset 0) is high for that one cycle.
- When undefined: no counter, no hold_expired_o port, and a grant lasts indefinitely.

Decomposition:
- Package rr_grant_arbiter_pkg holds:
  - typedef enum logic [0:0] {IDLE, GRANT} state_t;
  - default constants REQ_W_DEF = 4 and MAX_HOLD_DEF = 16;
  - function lowest_one(x) returning x & (~x + 1).
- One sub-module, onehot_to_idx: one-hot to binary encoder, parameterised on REQ_W.

Test Plan:
- Reset, then req_i = 4'b1111 held, done_i pulsed each grant → grant_o sequence 0001, 0010, 0100, 1000, 0001.
- Grant 1-cycle latency: req_i = 4'b0100 at cycle t → grant_o = 0100 and grant_idx_o = 2 at t+1. busy_o rises at the same time.
- Owner withdraw: grant 0010 active, req_i drops bit 1, req_i = 4'b1001 → next edge grant_o = 1000 (rotation from ptr = 1).
- Hold and isolation: grant 0001 held for 20 cycles while req_i toggles bits 1–3, done_i = 0 → grant_o stays 0001.
- srst_i asserted during grant 0100 → next edge all outputs zero. With req_i = 4'b0110, the grant after reset is 0010.
- With RR_GRANT_ARBITER_HOLD_LIMIT_EN and MAX_HOLD = 4, req_i = 4'b0011, done_i = 0 → grant 0001 for 4 cycles, hold_expired_o pulses, then grant 0010.
